sys_cmd_decoder: RTL and testbench

Receive-side system controller. It parses framed command bytes from the UART receiver and sequences the register file and ALU. Supported commands are register write, register read, ALU operation with operands, and ALU operation without operands. It drives the register-file read/write strobes, ALU enable, function code and the ALU clock-gate enable. Results flow back to the host through the transmit-side system controller.

---
 rtl/sys_cmd_decoder_if.sv | 36 +++
 rtl/sys_cmd_decoder.sv | 200 ++++++++++++++++++++
 tb/tb_sys_cmd_decoder.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sys_cmd_decoder_if.sv
// sys_cmd_decoder_if
// Bus bundle between the receive-side command decoder and its environment.
//   Rx_Data/Rx_valid/Rx_error : framed bytes from the UART receiver
//   ALU_out_valid             : ALU result valid pulse
//   Address/WrEn/WrData/RdEn  : register-file access
//   ALU_EN/ALU_FUN            : ALU start and function code
//   CLK_GATE_EN               : ALU clock-gate enable
//   Cmd_err                   : aborted / dropped frame pulse
// master modport: the decoder; slave modport: the surrounding system.
interface sys_cmd_decoder_if #(
   parameter int width      = 8,
   parameter int addr_width = 4
) ();
   logic [width-1:0]      Rx_Data;
   logic                  Rx_valid;
   logic                  Rx_error;
   logic                  ALU_out_valid;
   logic [addr_width-1:0] Address;
   logic                  WrEn;
   logic [width-1:0]      WrData;
   logic                  RdEn;
   logic                  ALU_EN;
   logic [3:0]            ALU_FUN;
   logic                  CLK_GATE_EN;
   logic                  Cmd_err;

   modport master (
      input  Rx_Data, Rx_valid, Rx_error, ALU_out_valid,
      output Address, WrEn, WrData, RdEn, ALU_EN, ALU_FUN, CLK_GATE_EN, Cmd_err
   );

   modport slave (
      output Rx_Data, Rx_valid, Rx_error, ALU_out_valid,
      input  Address, WrEn, WrData, RdEn, ALU_EN, ALU_FUN, CLK_GATE_EN, Cmd_err
   );
endinterface

// File: rtl/sys_cmd_decoder.sv
// sys_cmd_decoder
// Receive-side system controller: parses command frames
//   0xAA {addr, data} register write
//   0xBB {addr}       register read
//   0xCC {A, B, fun}  ALU op with operands (A -> reg 0, B -> reg 1)
//   0xDD {fun}        ALU op on current operands
// and sequences the register file and ALU.
// Ports:
//   CLK   : system clock
//   Reset : asynchronous active-low reset
//   bus   : sys_cmd_decoder_if.master (Rx byte stream in, strobes out)
// All outputs are registered. Optional build macro CMD_TIMEOUT_EN enables
// an idle-cycle watchdog (TIMEOUT cycles) that aborts partial frames.
module sys_cmd_decoder #(
   parameter int width      = 8,
   parameter int addr_width = 4,
   parameter int TIMEOUT    = 1023
) (
   input  logic                 CLK,
   input  logic                 Reset,
   sys_cmd_decoder_if.master    bus
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WR_ADDR  = 3'd1,
      WR_DATA  = 3'd2,
      RD_ADDR  = 3'd3,
      OPA      = 3'd4,
      OPB      = 3'd5,
      FUN      = 3'd6,
      ALU_WAIT = 3'd7
   } state_t;

   localparam logic [width-1:0]      OP_WR     = width'(8'hAA);
   localparam logic [width-1:0]      OP_RD     = width'(8'hBB);
   localparam logic [width-1:0]      OP_ALU    = width'(8'hCC);
   localparam logic [width-1:0]      OP_ALU_NO = width'(8'hDD);
   localparam logic [addr_width-1:0] ADDR_OPA  = {addr_width{1'b0}};
   localparam logic [addr_width-1:0] ADDR_OPB  = {{(addr_width-1){1'b0}}, 1'b1};

   state_t                state_r, state_s;
   logic [addr_width-1:0] addr_r, addr_s;
   logic [addr_width-1:0] address_r, address_s;
   logic [width-1:0]      wr_data_r, wr_data_s;
   logic [3:0]            alu_fun_r, alu_fun_s;
   logic                  wr_en_r, wr_en_s;
   logic                  rd_en_r, rd_en_s;
   logic                  alu_en_r, alu_en_s;
   logic                  cge_r, cge_s;
   logic                  cmd_err_r, cmd_err_s;
   logic                  timeout_s;

`ifdef CMD_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic             counting_s;

   // Watchdog: counts idle cycles inside a partial frame, fires one cycle
   // before the count would reach TIMEOUT so the abort lands on that edge.
   always_comb begin
      counting_s = (state_r != IDLE) && (state_r != ALU_WAIT);
      timeout_s  = 1'b0;
      cnt_s      = {CNT_W{1'b0}};
      if (bus.Rx_error || bus.Rx_valid || !counting_s) begin
         cnt_s = {CNT_W{1'b0}};
      end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
         timeout_s = 1'b1;
         cnt_s     = {CNT_W{1'b0}};
      end else begin
         cnt_s = cnt_r + CNT_W'(1);
      end
   end

   // Watchdog counter register.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) cnt_r <= {CNT_W{1'b0}};
      else        cnt_r <= cnt_s;
   end
`else
   localparam int unused_timeout = TIMEOUT;
   assign timeout_s = 1'b0;
`endif

   // Next-state and next-output decode; held outputs default to their current value.
   always_comb begin
      state_s   = state_r;
      addr_s    = addr_r;
      address_s = address_r;
      wr_data_s = wr_data_r;
      alu_fun_s = alu_fun_r;
      wr_en_s   = 1'b0;
      rd_en_s   = 1'b0;
      alu_en_s  = 1'b0;
      cmd_err_s = 1'b0;
      if (bus.Rx_error) begin
         // Receiver error aborts any frame; a same-cycle byte is discarded.
         state_s   = IDLE;
         cmd_err_s = 1'b1;
      end else if (state_r == ALU_WAIT) begin
         // Bytes arriving while the ALU is busy are dropped.
         if (bus.ALU_out_valid) state_s = IDLE;
         else                   state_s = ALU_WAIT;
         if (bus.Rx_valid) cmd_err_s = 1'b1;
         else              cmd_err_s = 1'b0;
      end else if (bus.Rx_valid) begin
         case (state_r)
            IDLE: begin
               case (bus.Rx_Data)
                  OP_WR:     state_s = WR_ADDR;
                  OP_RD:     state_s = RD_ADDR;
                  OP_ALU:    state_s = OPA;
                  OP_ALU_NO: state_s = FUN;
                  default: begin
                     state_s   = IDLE;
                     cmd_err_s = 1'b1;
                  end
               endcase
            end
            WR_ADDR: begin
               addr_s  = bus.Rx_Data[addr_width-1:0];
               state_s = WR_DATA;
            end
            WR_DATA: begin
               wr_en_s   = 1'b1;
               address_s = addr_r;
               wr_data_s = bus.Rx_Data;
               state_s   = IDLE;
            end
            RD_ADDR: begin
               rd_en_s   = 1'b1;
               address_s = bus.Rx_Data[addr_width-1:0];
               state_s   = IDLE;
            end
            OPA: begin
               wr_en_s   = 1'b1;
               address_s = ADDR_OPA;
               wr_data_s = bus.Rx_Data;
               state_s   = OPB;
            end
            OPB: begin
               wr_en_s   = 1'b1;
               address_s = ADDR_OPB;
               wr_data_s = bus.Rx_Data;
               state_s   = FUN;
            end
            FUN: begin
               alu_en_s  = 1'b1;
               alu_fun_s = bus.Rx_Data[3:0];
               state_s   = ALU_WAIT;
            end
            default: state_s = IDLE;
         endcase
      end else if (timeout_s) begin
         state_s   = IDLE;
         cmd_err_s = 1'b1;
      end else begin
         state_s = state_r;
      end
      // Gate tracks the next state so it rises entering FUN and falls leaving ALU_WAIT.
      cge_s = (state_s == FUN) || (state_s == ALU_WAIT);
   end

   // State and registered-output update.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state_r   <= IDLE;
         addr_r    <= {addr_width{1'b0}};
         address_r <= {addr_width{1'b0}};
         wr_data_r <= {width{1'b0}};
         alu_fun_r <= 4'h0;
         wr_en_r   <= 1'b0;
         rd_en_r   <= 1'b0;
         alu_en_r  <= 1'b0;
         cge_r     <= 1'b0;
         cmd_err_r <= 1'b0;
      end else begin
         state_r   <= state_s;
         addr_r    <= addr_s;
         address_r <= address_s;
         wr_data_r <= wr_data_s;
         alu_fun_r <= alu_fun_s;
         wr_en_r   <= wr_en_s;
         rd_en_r   <= rd_en_s;
         alu_en_r  <= alu_en_s;
         cge_r     <= cge_s;
         cmd_err_r <= cmd_err_s;
      end
   end

   assign bus.Address     = address_r;
   assign bus.WrData      = wr_data_r;
   assign bus.ALU_FUN     = alu_fun_r;
   assign bus.WrEn        = wr_en_r;
   assign bus.RdEn        = rd_en_r;
   assign bus.ALU_EN      = alu_en_r;
   assign bus.CLK_GATE_EN = cge_r;
   assign bus.Cmd_err     = cmd_err_r;

endmodule

// File: tb/tb_sys_cmd_decoder.sv
// Self-checking bench for sys_cmd_decoder: expected strobes are queued as
// bytes are driven and a negedge monitor pops and compares each strobe.
module tb_sys_cmd_decoder;

   typedef struct {
      logic [3:0] kind;   // {WrEn, RdEn, ALU_EN, Cmd_err}
      logic [3:0] addr;
      logic [7:0] data;
      logic [3:0] fun;
   } exp_t;

   logic CLK;
   logic Reset;
   int   n_vec;
   int   n_err;
   exp_t q[$];

   sys_cmd_decoder_if #(.width(8), .addr_width(4)) bus ();

   sys_cmd_decoder #(.width(8), .addr_width(4), .TIMEOUT(16)) dut (
      .CLK   (CLK),
      .Reset (Reset),
      .bus   (bus.master)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   function automatic void push_wr(input logic [3:0] a, input logic [7:0] d);
      exp_t e;
      e.kind = 4'b1000; e.addr = a; e.data = d; e.fun = 4'h0;
      q.push_back(e);
   endfunction

   function automatic void push_rd(input logic [3:0] a);
      exp_t e;
      e.kind = 4'b0100; e.addr = a; e.data = 8'h00; e.fun = 4'h0;
      q.push_back(e);
   endfunction

   function automatic void push_alu(input logic [3:0] f);
      exp_t e;
      e.kind = 4'b0010; e.addr = 4'h0; e.data = 8'h00; e.fun = f;
      q.push_back(e);
   endfunction

   function automatic void push_err();
      exp_t e;
      e.kind = 4'b0001; e.addr = 4'h0; e.data = 8'h00; e.fun = 4'h0;
      q.push_back(e);
   endfunction

   // Scoreboard monitor: every strobe cycle must match the head of the queue.
   always @(negedge CLK) begin
      logic [3:0] obs;
      exp_t       e;
      obs = {bus.WrEn, bus.RdEn, bus.ALU_EN, bus.Cmd_err};
      if (Reset === 1'b1 && obs !== 4'b0000) begin
         n_vec++;
         if (q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_strobe got=%b want=none t=%0t", obs, $time);
         end else begin
            e = q.pop_front();
            if (obs !== e.kind
                || (e.kind[3] && (bus.Address !== e.addr || bus.WrData !== e.data))
                || (e.kind[2] && bus.Address !== e.addr)
                || (e.kind[1] && bus.ALU_FUN !== e.fun)) begin
               n_err++;
               $display("FAIL strobe got kind=%b addr=%h data=%h fun=%h want kind=%b addr=%h data=%h fun=%h t=%0t",
                        obs, bus.Address, bus.WrData, bus.ALU_FUN,
                        e.kind, e.addr, e.data, e.fun, $time);
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic send(input logic [7:0] b);
      bus.Rx_Data  = b;
      bus.Rx_valid = 1'b1;
      @(negedge CLK);
      bus.Rx_valid = 1'b0;
   endtask

   task automatic pulse_alu_valid();
      bus.ALU_out_valid = 1'b1;
      @(negedge CLK);
      bus.ALU_out_valid = 1'b0;
   endtask

   task automatic check_cge(input string name, input logic want);
      n_vec++;
      if (bus.CLK_GATE_EN !== want) begin
         n_err++;
         $display("FAIL %s CLK_GATE_EN got=%b want=%b", name, bus.CLK_GATE_EN, want);
      end
   endtask

   task automatic check_all_zero(input string name);
      logic [20:0] got;
      got = {bus.Address, bus.WrData, bus.ALU_FUN, bus.WrEn, bus.RdEn,
             bus.ALU_EN, bus.CLK_GATE_EN, bus.Cmd_err};
      n_vec++;
      if (got !== 21'd0) begin
         n_err++;
         $display("FAIL %s outputs got=%h want=0", name, got);
      end
   endtask

   task automatic test_reset();
      Reset = 1'b0;
      bus.Rx_Data = 8'h00; bus.Rx_valid = 1'b0;
      bus.Rx_error = 1'b0; bus.ALU_out_valid = 1'b0;
      idle(3);
      check_all_zero("reset_values");
      Reset = 1'b1;
      idle(2);
      check_all_zero("after_reset_release");
   endtask

   task automatic test_write();
      push_wr(4'h5, 8'h3C);
      send(8'hAA); send(8'h05); send(8'h3C);
      idle(2);
      n_vec++;
      if (bus.Address !== 4'h5 || bus.WrData !== 8'h3C) begin
         n_err++;
         $display("FAIL write_hold got addr=%h data=%h want addr=5 data=3c", bus.Address, bus.WrData);
      end
   endtask

   task automatic test_read();
      push_rd(4'h7);
      send(8'hBB); send(8'h07);
      idle(2);
   endtask

   task automatic test_alu_ops();
      push_wr(4'h0, 8'h12); push_wr(4'h1, 8'h34); push_alu(4'h1);
      send(8'hCC); send(8'h12); send(8'h34); send(8'h01);
      check_cge("alu_start", 1'b1);
      idle(3);
      check_cge("alu_wait", 1'b1);
      pulse_alu_valid();
      check_cge("alu_done", 1'b0);
      n_vec++;
      if (bus.ALU_FUN !== 4'h1 || bus.Address !== 4'h1) begin
         n_err++;
         $display("FAIL alu_hold got fun=%h addr=%h want fun=1 addr=1", bus.ALU_FUN, bus.Address);
      end
   endtask

   task automatic test_bad_opcode();
      push_err();
      send(8'h55);
      idle(2);
   endtask

   task automatic test_rx_error();
      send(8'hAA); send(8'h02);
      push_err();
      bus.Rx_error = 1'b1;
      @(negedge CLK);
      bus.Rx_error = 1'b0;
      push_rd(4'h4);
      send(8'hBB); send(8'h04);
      // Error together with a byte: byte must be discarded.
      send(8'hAA);
      push_err();
      bus.Rx_error = 1'b1;
      send(8'h09);
      bus.Rx_error = 1'b0;
      push_rd(4'h9);
      send(8'hBB); send(8'h09);
      idle(2);
   endtask

   task automatic test_alu_wait_drop();
      push_alu(4'h3);
      send(8'hDD); send(8'h03);
      check_cge("drop_start", 1'b1);
      push_err();
      send(8'h44);
      check_cge("drop_stays_busy", 1'b1);
      push_err();
      bus.ALU_out_valid = 1'b1;
      send(8'h66);
      bus.ALU_out_valid = 1'b0;
      check_cge("drop_with_done", 1'b0);
      push_rd(4'h2);
      send(8'hBB); send(8'h02);
      idle(2);
   endtask

   task automatic test_back_to_back();
      push_wr(4'hA, 8'h5A); push_rd(4'hA); push_wr(4'h6, 8'hC3);
      send(8'hAA); send(8'h0A); send(8'h5A);
      send(8'hBB); send(8'h0A);
      send(8'hAA); send(8'h06); send(8'hC3);
      idle(2);
   endtask

   task automatic test_upper_bits();
      push_wr(4'h3, 8'hF0);
      send(8'hAA); send(8'hF3); send(8'hF0);
      push_rd(4'hC);
      send(8'hBB); send(8'h9C);
      push_alu(4'hA);
      send(8'hDD); send(8'hFA);
      pulse_alu_valid();
      idle(2);
   endtask

`ifdef CMD_TIMEOUT_EN
   task automatic test_timeout();
      send(8'hDD);
      idle(15);
      n_vec++;
      if (bus.Cmd_err !== 1'b0) begin
         n_err++;
         $display("FAIL timeout_early Cmd_err got=%b want=0", bus.Cmd_err);
      end
      push_err();
      idle(1);
      check_cge("timeout_gate", 1'b0);
      push_alu(4'h2);
      send(8'hDD); send(8'h02);
      pulse_alu_valid();
      idle(2);
   endtask
`endif

   task automatic test_reset_mid_frame();
      push_wr(4'h0, 8'h12);
      send(8'hCC); send(8'h12);
      #2 Reset = 1'b0;
      #1 check_all_zero("reset_in_opb");
      @(negedge CLK);
      Reset = 1'b1;
      push_alu(4'h8);
      send(8'hDD); send(8'h08);
      check_cge("after_reset_alu", 1'b1);
      pulse_alu_valid();
      idle(2);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_write();
      test_read();
      test_alu_ops();
      test_bad_opcode();
      test_rx_error();
      test_alu_wait_drop();
      test_back_to_back();
      test_upper_bits();
`ifdef CMD_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid_frame();
      idle(4);
      n_vec++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL missing_strobes got pending=%0d want=0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
